// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: strips V/B substitution pulses from ternary symbols, flags code errors.
// Latency 4 accepts; never stalls the line. Build with HDB3_DEC_ERR_CNT_EN for a saturating err_cnt.
module hdb3_decoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           data_in,
  output logic                 data_out,
  output logic                 out_valid,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [3:0] w;
  logic [3:0] w_nxt;
  logic [2:0] fill;
  logic [2:0] fill_nxt;
  logic [2:0] zrun;
  logic [2:0] zrun_nxt;
  logic       last_pol;
  logic       last_pol_nxt;
  logic       pol_seen;
  logic       pol_seen_nxt;
  logic       is_pulse;
  logic       is_illegal;
  logic       is_viol;
  logic       err_nxt;

  always_comb begin
    is_pulse     = (data_in == 2'b10) || (data_in == 2'b01);
    is_illegal   = (data_in == 2'b11);
    is_viol      = is_pulse && pol_seen && (data_in[1] == last_pol);
    w_nxt        = w;
    fill_nxt     = fill;
    zrun_nxt     = zrun;
    last_pol_nxt = last_pol;
    pol_seen_nxt = pol_seen;
    err_nxt      = 1'b0;

    if (in_valid) begin
      w_nxt = {w[2:0], 1'b0};
      if (fill != 3'd4) begin
        fill_nxt = fill + 3'd1;
      end
      if (is_pulse) begin
        zrun_nxt = 3'd0;
        if (is_viol) begin
          // Clearing the three shifted positions drops the B of a B00V group.
          w_nxt   = 4'b0000;
          err_nxt = w[0] | w[1];
        end else begin
          w_nxt[0]     = 1'b1;
          last_pol_nxt = data_in[1];
          pol_seen_nxt = 1'b1;
        end
      end else begin
        if (zrun != 3'd7) begin
          zrun_nxt = zrun + 3'd1;
        end
        err_nxt = is_illegal || (zrun == 3'd3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w         <= 4'b0000;
      fill      <= 3'd0;
      zrun      <= 3'd0;
      last_pol  <= 1'b0;
      pol_seen  <= 1'b0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      w         <= w_nxt;
      fill      <= fill_nxt;
      zrun      <= zrun_nxt;
      last_pol  <= last_pol_nxt;
      pol_seen  <= pol_seen_nxt;
      out_valid <= in_valid && (fill == 3'd4);
      err       <= err_nxt;
      if (in_valid) begin
        data_out <= w[3];
      end
    end
  end

`ifdef HDB3_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (err_nxt && (cnt != {ERR_CNT_W{1'b1}})) begin
      cnt <= cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
